// File: rtl/risky_pkg.sv
// Shared types and constants for the unified memory port arbiter and
// the byte-enable legality check.
package risky_pkg;

    localparam int MEM_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        ERR     = 2'd3
    } arb_state_t;

    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    // Low two address bits are never used; lanes come from the byte enables.
    function automatic logic [MEM_ADDR_W-1:0] word_align(input logic [MEM_ADDR_W-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mem_be_check.sv
// Byte-enable legality check: single bytes, aligned halves or the full word.
module mem_be_check
    import risky_pkg::*;
(
    input  logic [3:0] be,
    output logic       legal
);

    // Whitelist of naturally aligned access sizes; everything else is an error.
    always_comb begin
        legal = 1'b0;
        case (be)
            BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3,
            BE_HALF0, BE_HALF1, BE_WORD: legal = 1'b1;
            default:                     legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access, one
// transaction at a time, data first with a bounded fetch starvation window.
module mem_arbiter
    import risky_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_i,
    input  logic [MEM_ADDR_W-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_valid_o,
    output logic [31:0]           if_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [3:0]            d_be_i,
    input  logic [MEM_ADDR_W-1:0] d_addr_i,
    input  logic [31:0]           d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_valid_o,
    output logic [31:0]           d_rdata_o,
    output logic                  d_err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [31:0]           mem_rdata_i
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    arb_state_t            state_r;
    arb_state_t            state_next_s;
    logic [3:0]            streak_r;
    logic                  be_legal_s;
    logic                  grant_d_s;
    logic                  grant_if_s;
    logic                  req_r;
    logic                  we_r;
    logic [3:0]            be_r;
    logic [MEM_ADDR_W-1:0] addr_r;
    logic [31:0]           wdata_r;
    logic                  if_valid_r;
    logic [31:0]           if_rdata_r;
    logic                  d_valid_r;
    logic                  d_err_r;
    logic [31:0]           d_rdata_r;

    mem_be_check u_be_check (
        .be    (d_be_i),
        .legal (be_legal_s)
    );

    // Arbitration and next-state; grants only leave IDLE and are masked in reset.
    always_comb begin
        grant_d_s    = 1'b0;
        grant_if_s   = 1'b0;
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (rst_n && d_req_i && ((streak_r < STREAK_MAX) || !if_req_i)) begin
                    grant_d_s    = 1'b1;
                    state_next_s = be_legal_s ? BUSY_D : ERR;
                end else if (rst_n && if_req_i) begin
                    grant_if_s   = 1'b1;
                    state_next_s = BUSY_IF;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ack_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            ERR:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Consecutive data grants while fetch waits; saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_r <= 4'd0;
        end else if (grant_if_s) begin
            streak_r <= 4'd0;
        end else if (grant_d_s) begin
            if (!if_req_i) begin
                streak_r <= 4'd0;
            end else if (streak_r >= STREAK_MAX) begin
                streak_r <= STREAK_MAX;
            end else begin
                streak_r <= streak_r + 4'd1;
            end
        end
    end

    // Transaction capture at grant; the memory port is driven from these copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            be_r    <= 4'd0;
            addr_r  <= '0;
            wdata_r <= 32'd0;
        end else if (grant_d_s) begin
            req_r   <= be_legal_s;
            we_r    <= d_we_i;
            be_r    <= d_be_i;
            addr_r  <= word_align(d_addr_i);
            wdata_r <= d_wdata_i;
        end else if (grant_if_s) begin
            req_r   <= 1'b1;
            we_r    <= 1'b0;
            be_r    <= BE_WORD;
            addr_r  <= word_align(if_addr_i);
            wdata_r <= 32'd0;
        end else if (req_r && mem_ack_i) begin
            req_r   <= 1'b0;
        end
    end

    // Completion pulses and held read data; errors complete without memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid_r <= 1'b0;
            if_rdata_r <= 32'd0;
            d_valid_r  <= 1'b0;
            d_err_r    <= 1'b0;
            d_rdata_r  <= 32'd0;
        end else begin
            if_valid_r <= 1'b0;
            d_valid_r  <= 1'b0;
            d_err_r    <= 1'b0;
            if (state_r == BUSY_IF && mem_ack_i) begin
                if_valid_r <= 1'b1;
                if_rdata_r <= mem_rdata_i;
            end
            if (state_r == BUSY_D && mem_ack_i) begin
                d_valid_r <= 1'b1;
                d_rdata_r <= we_r ? 32'd0 : mem_rdata_i;
            end else if (grant_d_s && !be_legal_s) begin
                d_valid_r <= 1'b1;
                d_err_r   <= 1'b1;
                d_rdata_r <= 32'd0;
            end
        end
    end

    assign if_gnt_o    = grant_if_s;
    assign d_gnt_o     = grant_d_s;
    assign if_valid_o  = if_valid_r;
    assign if_rdata_o  = if_rdata_r;
    assign d_valid_o   = d_valid_r;
    assign d_err_o     = d_err_r;
    assign d_rdata_o   = d_rdata_r;
    assign mem_req_o   = req_r;
    assign mem_we_o    = we_r;
    assign mem_be_o    = be_r;
    assign mem_addr_o  = addr_r;
    assign mem_wdata_o = wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int MAX    = 4;
    localparam int M_IDLE = 0;
    localparam int M_BUSY = 1;
    localparam int M_ERR  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = 32'd0;
    logic        if_gnt_o, if_valid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i = 1'b0, d_we_i = 1'b0;
    logic [3:0]  d_be_i = 4'd0;
    logic [31:0] d_addr_i = 32'd0, d_wdata_i = 32'd0;
    logic        d_gnt_o, d_valid_o, d_err_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i;

    logic [31:0] phys    [0:63];
    logic [31:0] ref_mem [0:63];
    logic [3:0]  be_tab  [0:11] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100,
                                    4'b1111, 4'b0000, 4'b0101, 4'b1010, 4'b0111, 4'b1110};

    int          n_tests = 0, n_fail = 0;
    int          m_st, m_streak;
    logic        m_port_d, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic        m_if_valid, m_d_valid, m_d_err;
    logic [31:0] m_if_rdata, m_d_rdata;
    logic        g_if, g_d;

    mem_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_valid_o(d_valid_o),
        .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    assign mem_rdata_i = phys[mem_addr_o[7:2]];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_streak = 0;
        m_if_valid = 1'b0; m_d_valid = 1'b0; m_d_err = 1'b0;
        m_if_rdata = 32'd0; m_d_rdata = 32'd0;
        g_if = 1'b0; g_d = 1'b0;
    endtask

    // Compare this cycle's outputs to the model, then advance the model to the next edge.
    task automatic model_step();
        logic eg_d, eg_if;
        eg_d = 1'b0; eg_if = 1'b0;
        if (m_st == M_IDLE) begin
            if (d_req_i && (m_streak < MAX || !if_req_i)) eg_d = 1'b1;
            else if (if_req_i) eg_if = 1'b1;
        end
        check_eq("d_gnt", d_gnt_o, eg_d);
        check_eq("if_gnt", if_gnt_o, eg_if);
        check_eq("mem_req", mem_req_o, m_st == M_BUSY);
        check_eq("if_valid", if_valid_o, m_if_valid);
        check_eq("d_valid", d_valid_o, m_d_valid);
        check_eq("d_err", d_err_o, m_d_err);
        check_eq("if_rdata", if_rdata_o, m_if_rdata);
        check_eq("d_rdata", d_rdata_o, m_d_rdata);
        if (m_st == M_BUSY) begin
            check_eq("mem_addr", mem_addr_o, {m_addr[31:2], 2'b00});
            check_eq("mem_be", mem_be_o, m_be);
            check_eq("mem_we", mem_we_o, m_we);
            if (m_we) check_eq("mem_wdata", mem_wdata_o, m_wdata);
        end
        if (mem_req_o && mem_ack_i && mem_we_o)
            phys[mem_addr_o[7:2]] = merge(phys[mem_addr_o[7:2]], mem_wdata_o, mem_be_o);
        g_d = d_gnt_o; g_if = if_gnt_o;
        m_if_valid = 1'b0; m_d_valid = 1'b0; m_d_err = 1'b0;
        if (m_st == M_BUSY) begin
            if (mem_ack_i) begin
                if (!m_port_d) begin
                    m_if_valid = 1'b1; m_if_rdata = ref_mem[m_addr[7:2]];
                end else if (m_we) begin
                    ref_mem[m_addr[7:2]] = merge(ref_mem[m_addr[7:2]], m_wdata, m_be);
                    m_d_valid = 1'b1; m_d_rdata = 32'd0;
                end else begin
                    m_d_valid = 1'b1; m_d_rdata = ref_mem[m_addr[7:2]];
                end
                m_st = M_IDLE;
            end
        end else if (m_st == M_ERR) begin
            m_st = M_IDLE;
        end else if (eg_d) begin
            m_streak = if_req_i ? m_streak + 1 : 0;
            m_port_d = 1'b1; m_we = d_we_i; m_be = d_be_i; m_addr = d_addr_i; m_wdata = d_wdata_i;
            if (d_be_i inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}) begin
                m_st = M_BUSY;
            end else begin
                m_st = M_ERR; m_d_valid = 1'b1; m_d_err = 1'b1; m_d_rdata = 32'd0;
            end
        end else if (eg_if) begin
            m_streak = 0;
            m_port_d = 1'b0; m_we = 1'b0; m_be = 4'b1111; m_addr = if_addr_i; m_wdata = 32'd0;
            m_st = M_BUSY;
        end
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_ctl"}, {if_gnt_o, if_valid_o, d_gnt_o, d_valid_o, d_err_o,
                                 mem_req_o, mem_we_o, mem_be_o}, 32'd0);
        check_eq({tag, "_rdata"}, if_rdata_o | d_rdata_o, 32'd0);
        check_eq({tag, "_mem"}, mem_addr_o | mem_wdata_o, 32'd0);
    endtask

    task automatic drain();
        d_req_i = 1'b0; if_req_i = 1'b0; mem_ack_i = 1'b1;
        repeat (4) tick();
        mem_ack_i = 1'b0;
    endtask

    task automatic drive_random();
        if (g_d || !d_req_i) begin
            d_req_i   = ($urandom_range(0, 2) != 0);
            d_we_i    = 1'($urandom_range(0, 1));
            d_be_i    = be_tab[$urandom_range(0, 11)];
            d_addr_i  = $urandom;
            d_wdata_i = $urandom;
        end else if ($urandom_range(0, 15) == 0) begin
            d_req_i = 1'b0;
        end
        if (g_if || !if_req_i) begin
            if_req_i  = ($urandom_range(0, 2) != 0);
            if_addr_i = $urandom;
        end else if ($urandom_range(0, 15) == 0) begin
            if_req_i = 1'b0;
        end
        mem_ack_i = (m_st == M_BUSY) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        logic [9:0] gseq;
        int         ng;
        for (int i = 0; i < 64; i++) begin
            phys[i] = $urandom;
            ref_mem[i] = phys[i];
        end
        model_reset();

        // Reset held with both requests pending, then data wins first.
        d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'b1111; d_addr_i = 32'h0000_0008;
        if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        model_reset();
        sample();
        check_eq("rst_first_d", d_gnt_o, 1'b1);
        advance();
        drain();

        // Fetch only, ack two cycles after the grant.
        phys[1] = 32'h0013_0093; ref_mem[1] = 32'h0013_0093;
        if_req_i = 1'b1; if_addr_i = 32'h0000_0106;
        sample(); check_eq("fetch_gnt", if_gnt_o, 1'b1); advance();
        if_req_i = 1'b0;
        sample();
        check_eq("fetch_addr", mem_addr_o, 32'h0000_0104);
        check_eq("fetch_be", mem_be_o, 4'b1111);
        advance();
        mem_ack_i = 1'b1; tick(); mem_ack_i = 1'b0;
        sample();
        check_eq("fetch_valid", if_valid_o, 1'b1);
        check_eq("fetch_rdata", if_rdata_o, 32'h0013_0093);
        advance();

        // Half-word store to the upper lanes, zero-wait memory.
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b1100; d_addr_i = 32'h0000_0020;
        d_wdata_i = 32'hABCD_0000;
        sample(); check_eq("st_gnt", d_gnt_o, 1'b1); advance();
        d_req_i = 1'b0; mem_ack_i = 1'b1;
        sample();
        check_eq("st_we", mem_we_o, 1'b1);
        check_eq("st_be", mem_be_o, 4'b1100);
        advance();
        mem_ack_i = 1'b0;
        sample();
        check_eq("st_valid", {d_valid_o, d_err_o}, 2'b10);
        check_eq("st_rdata", d_rdata_o, 32'd0);
        advance();

        // Illegal byte enables complete with an error and never reach memory.
        d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'b0101; d_addr_i = 32'h0000_0030;
        sample(); check_eq("ill_gnt", d_gnt_o, 1'b1); advance();
        d_req_i = 1'b0;
        sample();
        check_eq("ill_valid_err", {d_valid_o, d_err_o, mem_req_o}, 3'b110);
        advance();
        sample(); check_eq("ill_no_req", mem_req_o, 1'b0); advance();

        // Starvation bound with both ports requesting back to back.
        gseq = 10'd0; ng = 0;
        if_req_i = 1'b1; d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'b1111;
        for (int c = 0; c < 80 && ng < 10; c++) begin
            sample();
            if (d_gnt_o) begin gseq[9-ng] = 1'b1; ng++; end
            else if (if_gnt_o) begin gseq[9-ng] = 1'b0; ng++; end
            advance();
            if (g_d) d_addr_i = $urandom;
            if (g_if) if_addr_i = $urandom;
            mem_ack_i = (m_st == M_BUSY);
        end
        check_eq("starve_cnt", ng, 10);
        check_eq("starve_order", gseq, 10'b1111011110);
        drain();

        // Reset during a data access drops the request and loses the access.
        d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'b1111; d_addr_i = 32'h0000_0040;
        tick();
        d_req_i = 1'b0;
        check_eq("mid_busy", mem_req_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_req_drop", mem_req_o, 1'b0);
        @(posedge clk);
        #1;
        check_zero("mid_reset");
        rst_n = 1'b1;
        model_reset();
        d_req_i = 1'b1;
        tick();
        d_req_i = 1'b0; mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        sample();
        check_eq("mid_reissue_valid", d_valid_o, 1'b1);
        check_eq("mid_reissue_rdata", d_rdata_o, ref_mem[16]);
        advance();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one unified memory port between the fetch stage (instruction reads) and the mem_access stage (data loads/stores). It sits between the pipeline and the memory model, and replaces the separate instruction and data memory buses. It serialises one transaction at a time, gives data accesses priority with a bounded-starvation guarantee for fetch, and rejects illegal byte-enable patterns without touching memory.

## Interface
- MAX_DATA_STREAK, default 4: maximum consecutive data grants while a fetch request is pending; legal range 1..15.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- if_req_i  input  1  fetch requests an instruction read.
- if_addr_i  input  32  fetch byte address; bits [1:0] are ignored.
- if_gnt_o  output  1  fetch request accepted this cycle.
- if_valid_o  output  1  one-cycle pulse; if_rdata_o is valid.
- if_rdata_o  output  32  instruction word.
- d_req_i  input  1  data access request.
- d_we_i  input  1  1 = store, 0 = load.
- d_be_i  input  4  byte enables.
- d_addr_i  input  32  data byte address; bits [1:0] are ignored, lanes are selected by d_be_i.
- d_wdata_i  input  32  store data, lane-aligned.
- d_gnt_o  output  1  data request accepted this cycle.
- d_valid_o  output  1  one-cycle completion pulse for loads, stores and errors.
- d_rdata_o  output  32  load data; 0 on store or error completion.
- d_err_o  output  1  qualifies d_valid_o; illegal byte-enable pattern.
- mem_req_o  output  1  memory transaction request; held until acknowledged.
- mem_we_o  output  1  memory write.
- mem_be_o  output  4  memory byte enables; 4'b1111 for fetch.
- mem_addr_o  output  32  word-aligned address, {addr[31:2], 2'b00}.
- mem_wdata_o  output  32  write data.
- mem_ack_i  input  1  memory completes the transaction; mem_rdata_i is valid in the same cycle.
- mem_rdata_i  input  32  read data.

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_D, ERR.
- **Grant decision (IDLE only):**
  - d_req_i with a streak below the limit → data wins.
  - d_req_i and if_req_i with the streak equal to MAX_DATA_STREAK → fetch wins.
  - Otherwise fetch wins if if_req_i.
- **Grant pulse:** a one-cycle if_gnt_o or d_gnt_o, combinational in IDLE. Address, data, we and be are captured into registers on the same edge.
- **Data grant with legal be:** legal patterns are 0001, 0010, 0100, 1000, 0011, 1100, 1111 → BUSY_D.
- **Data grant with illegal be** (including 0000) → ERR. No memory request is issued.
- **Fetch grant** → BUSY_IF.
- **BUSY_IF / BUSY_D:**
  - mem_* is driven from the registered copies; mem_req_o = 1.
  - On mem_ack_i: capture mem_rdata_i, pulse the matching valid next cycle, return to IDLE.
- **ERR:** d_valid_o = 1, d_err_o = 1, d_rdata_o = 0 for one cycle, then IDLE.
- **Streak counter (4 bits):**
  - Increments on a data grant while if_req_i = 1.
  - Clears on a fetch grant, or on a data grant with if_req_i = 0.
  - Saturates at MAX_DATA_STREAK.
- **Requester obligations:** requesters hold req and payload stable until the grant; a request may be withdrawn before it is granted. No grant is issued outside IDLE.

## Timing
- **Reset values:** state IDLE, streak 0; every output 0, including mem_req_o, rdata and gnt.
- **Reset mid-transaction:** mem_req_o drops immediately (asynchronously). The in-flight access is discarded with no valid pulse. Requesters re-issue.
- **Latency:**
  - Grant at cycle 0.
  - mem_req_o from cycle 1.
  - Ack at cycle k (k ≥ 1).
  - valid at cycle k+1 (FSM is IDLE in that same cycle).
  - Next grant is possible at k+1.
- **Zero-wait memory (ack in cycle 1):** 3-cycle round trip; maximum throughput is one transaction per 2 cycles.
- **Error path:** grant at 0, d_valid_o/d_err_o at 1, next grant at 2.
- **Unexpected ack:** mem_ack_i in IDLE or ERR is ignored.
- **Simultaneous events:** valid and a new grant may coincide in the same cycle.
- **Output registration:** if_rdata_o and d_rdata_o are registered and hold their value until the next valid of the same port.

## Structure
- risky_pkg holds:
  - the arb_state_t enum (IDLE, BUSY_IF, BUSY_D, ERR);
  - the legal byte-enable constants;
  - MEM_ADDR_W = 32.
- Sub-module mem_be_check: purely combinational; d_be_i → legal flag. It will be reused later by the load/store unit.

## Test plan
- **Reset:** hold rst_n = 0 with requests pending → all outputs 0. Release → the first grant goes to the pending data request.
- **Fetch only:** if_addr_i = 0x0000_0106, mem ack after 2 cycles with rdata 0x0013_0093 → mem_addr_o = 0x104, mem_be_o = 1111; if_valid_o pulses at cycle 3 with if_rdata_o = 0x0013_0093.
- **Store with be = 1100:** addr 0x20, wdata 0xABCD_0000, zero-wait ack → mem_we_o = 1 and mem_be_o = 1100 in cycle 1; d_valid_o = 1 and d_err_o = 0 in cycle 2; d_rdata_o = 0.
- **Starvation bound:** with MAX_DATA_STREAK = 4, both ports request continuously → grant order D D D D I D D D D I …
- **Illegal be = 0101:** → d_gnt_o, then d_valid_o = 1 and d_err_o = 1 next cycle; mem_req_o never asserts.
- **Reset mid-transaction:** assert rst_n low during BUSY_D → mem_req_o falls in the same cycle; no d_valid_o; after release, a re-issued request completes normally.
